fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//   Shares one fifo_top instance between two producer cores (core0/core1 of the dual-core
//   attention datapath). Round-robin, burst-limited write arbitration. Tracks FIFO occupancy
//   so the consumer gets empty/count status, which fifo_top does not expose. Gates reads on empty.
//   Sits between the core output stages and the shared FIFO write/read strobes.
// PARAMETERS
//   bw     4   bits per lane (matches fifo_top bw)
//   width  1   lanes per word; data word = width*bw bits
//   depth  64  FIFO depth; must equal the attached fifo_top depth
//   burst  4   max consecutive words granted to one core before re-arbitration (>=1)
// PORTS
//   clk        in   1         clock; all state updates on rising edge
//   reset      in   1         asynchronous, active-high reset
//   req0       in   1         core0 has a word on in0; held until ack0
//   in0        in   width*bw  core0 write data
//   ack0       out  1         core0 word accepted this cycle (combinational)
//   req1       in   1         core1 has a word on in1; held until ack1
//   in1        in   width*bw  core1 write data
//   ack1       out  1         core1 word accepted this cycle (combinational)
//   fifo_full  in   1         fifo_top o_full
//   fifo_wr    out  1         fifo_top wr strobe
//   fifo_in    out  width*bw  fifo_top write data
//   rd_req     in   1         consumer wants one word
//   fifo_rd    out  1         fifo_top rd strobe
//   count      out  clog2(depth+1)  registered occupancy, 0..depth
//   o_empty    out  1         registered, 1 when count==0
//   grant_id   out  1         registered; core currently granted (valid when busy)
//   busy       out  1         registered; 1 in GNT0/GNT1
// BEHAVIOUR
//   Reset (async, immediate): state=IDLE, last=1 (core0 wins first tie), bcnt=0, count=0,
//     o_empty=1, grant_id=0, busy=0; ack0/ack1/fifo_wr/fifo_rd=0 while reset asserted.
//   FSM states IDLE, GNT0, GNT1. Writes occur only in GNTk.
//   wr_ok = !fifo_full && (count < depth). Write when in GNTk: fifo_wr=ackk=reqk&&wr_ok,
//     fifo_in=ink (fifo_in=in0 in IDLE/GNT0, in1 in GNT1); no write path from IDLE.
//   IDLE: req0&&req1 -> GNT(!last); only reqk -> GNTk; none -> IDLE. First write lands 1 cycle
//     after req is seen in IDLE (grant is registered).
//   GNTk: bcnt increments on each write. Leave GNTk when (write && bcnt==burst-1) or !reqk;
//     on leave: bcnt=0, last=k, next = GNT(other) if req(other), else GNTk if reqk, else IDLE.
//     Handoff GNT0->GNT1 has no bubble: first core1 write can occur the cycle after handoff.
//   Full stall: in GNTk with reqk && !wr_ok: no write, no ack, bcnt holds, state holds
//     (grant kept; other core waits).
//   Read: fifo_rd = rd_req && (count != 0). Read while empty is dropped, no underflow.
//   count: +1 on fifo_wr only, -1 on fifo_rd only, unchanged when both or neither.
//     Simultaneous rd and wr at count==depth: write still blocked (conservative), read proceeds.
//   o_empty, busy, grant_id derived from next-state registers (no comb path from inputs).
//   Reset mid-burst drops state and count; fifo_top must share the same reset so contents agree.
// TESTING
//   T1 reset: assert reset mid-traffic -> count=0, o_empty=1, busy=0, all strobes 0 immediately.
//   T2 tie: req0=req1=1 held, burst=4 -> acks 0,0,0,0,1,1,1,1,0,... no idle cycles between bursts.
//   T3 single: only req1, 10 words -> GNT1 re-enters itself every 4 words; 10 writes, count=10.
//   T4 full: fill to 64, keep req0 -> fifo_wr=0, ack0=0, count=64; one rd_req -> count=63, write resumes next cycle.
//   T5 empty: rd_req with count=0 -> fifo_rd=0, count stays 0; rd_req & write same cycle at count=5 -> count=5.
//   T6 drop: req0 falls after 2 of 4 words with req1 high -> next cycle GNT1, grant_id=1.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: producer, consumer and FIFO strobe bundle for fifo_wr_arbiter
//   req0/in0/ack0, req1/in1/ack1 : two producer cores, req held until ack
//   fifo_full/fifo_wr/fifo_in    : shared fifo_top write side
//   rd_req/fifo_rd               : consumer read request and gated fifo_top read strobe
//   count/o_empty                : registered occupancy status
//   grant_id/busy                : registered arbitration status
interface fifo_wr_arbiter_if #(parameter int bw = 4, parameter int width = 1, parameter int depth = 64);
  logic req0;
  logic [width*bw-1:0] in0;
  logic ack0;
  logic req1;
  logic [width*bw-1:0] in1;
  logic ack1;
  logic fifo_full;
  logic fifo_wr;
  logic [width*bw-1:0] fifo_in;
  logic rd_req;
  logic fifo_rd;
  logic [$clog2(depth+1)-1:0] count;
  logic o_empty;
  logic grant_id;
  logic busy;
  modport slave (
    input req0, in0, req1, in1, fifo_full, rd_req,
    output ack0, ack1, fifo_wr, fifo_in, fifo_rd, count, o_empty, grant_id, busy
  );
  modport master (
    output req0, in0, req1, in1, fifo_full, rd_req,
    input ack0, ack1, fifo_wr, fifo_in, fifo_rd, count, o_empty, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst-limited write arbiter for two cores sharing one fifo_top
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : fifo_wr_arbiter_if.slave (producer handshakes, FIFO strobes, status)
module fifo_wr_arbiter #(
  parameter int bw = 4,
  parameter int width = 1,
  parameter int depth = 64,
  parameter int burst = 4
) (
  input logic clk,
  input logic reset,
  fifo_wr_arbiter_if.slave bus
);
  localparam int cw = $clog2(depth + 1);
  localparam int bcw = burst > 1 ? $clog2(burst) : 1;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state_q, state_d;
  logic last_q, last_d;
  logic [bcw-1:0] bcnt_q, bcnt_d;
  logic [cw-1:0] count_q, count_d;
  logic empty_q, grant_q, busy_q;
  logic wr_ok, req_k, req_o, wr, rd, leave;
  always_comb begin
    wr_ok = !bus.fifo_full && (count_q < cw'(depth));
    req_k = state_q == GNT1 ? bus.req1 : bus.req0;
    req_o = state_q == GNT1 ? bus.req0 : bus.req1;
    wr = state_q != IDLE && req_k && wr_ok;
    rd = bus.rd_req && count_q != '0;
    // a stalled grant (req held, FIFO full) neither writes nor leaves
    leave = (wr && bcnt_q == bcw'(burst - 1)) || !req_k;
    state_d = state_q;
    last_d = last_q;
    bcnt_d = bcnt_q;
    if (state_q == IDLE)
      state_d = bus.req0 && bus.req1 ? (last_q ? GNT0 : GNT1) :
                bus.req0 ? GNT0 : bus.req1 ? GNT1 : IDLE;
    else if (leave) begin
      bcnt_d = '0;
      last_d = state_q == GNT1;
      state_d = req_o ? (state_q == GNT1 ? GNT0 : GNT1) : req_k ? state_q : IDLE;
    end else
      bcnt_d = bcnt_q + bcw'(wr);
    count_d = wr && !rd ? count_q + cw'(1) : rd && !wr ? count_q - cw'(1) : count_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      bcnt_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      grant_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      bcnt_q <= bcnt_d;
      count_q <= count_d;
      empty_q <= count_d == '0;
      grant_q <= state_d == GNT1;
      busy_q <= state_d != IDLE;
    end
  end
  assign bus.ack0 = wr && state_q == GNT0;
  assign bus.ack1 = wr && state_q == GNT1;
  assign bus.fifo_wr = wr;
  assign bus.fifo_in = state_q == GNT1 ? bus.in1 : bus.in0;
  assign bus.fifo_rd = rd;
  assign bus.count = count_q;
  assign bus.o_empty = empty_q;
  assign bus.grant_id = grant_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  fifo_wr_arbiter_if #(.bw(4), .width(1), .depth(64)) bus();
  fifo_wr_arbiter #(.bw(4), .width(1), .depth(64), .burst(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [4:0] sb[$];
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int nwr = 0;
  int first_wr = -1;
  int last_wr = -1;
  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  always @(posedge clk) cyc <= cyc + 1;
  // producer cores: present queue head, hold req until acked
  initial begin
    logic a0, a1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
    forever begin
      @(negedge clk);
      a0 = bus.ack0;
      a1 = bus.ack1;
      @(posedge clk);
      #1;
      if (a0 && q0.size() != 0) void'(q0.pop_front());
      if (a1 && q1.size() != 0) void'(q1.pop_front());
      bus.req0 = q0.size() != 0;
      bus.req1 = q1.size() != 0;
      bus.in0 = q0.size() != 0 ? q0[0] : 4'h0;
      bus.in1 = q1.size() != 0 ? q1[0] : 4'h0;
    end
  end
  // monitor: every FIFO write must match the next expected {core, word}
  always @(negedge clk) begin
    if (!reset && bus.fifo_wr) begin
      nwr++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (sb.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        logic [4:0] e;
        e = sb.pop_front();
        chk("wr_word", {bus.ack1, bus.fifo_in}, e);
        chk("ack_onehot", int'(bus.ack0) + int'(bus.ack1), 1);
      end
    end
  end
  task automatic send(bit id, int n, int base);
    for (int i = 0; i < n; i++) begin
      logic [3:0] d;
      d = 4'(base + i);
      if (id) q1.push_back(d);
      else q0.push_back(d);
      sb.push_back({id, d});
    end
  endtask
  task automatic wait_idle(int maxc, string name);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, int'(n < maxc), 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic drain(int n);
    bus.rd_req = 1'b1;
    repeat (n) @(negedge clk);
    bus.rd_req = 1'b0;
  endtask
  task automatic clr_span();
    nwr = 0;
    first_wr = -1;
    last_wr = -1;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    bus.rd_req = 1'b0;
    bus.fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.o_empty, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_grant", bus.grant_id, 0);
    // tie: core0 wins first, bursts of 4 alternate with no bubble
    clr_span();
    for (int i = 0; i < 8; i++) begin
      q0.push_back(4'(i));
      q1.push_back(4'(i + 8));
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) sb.push_back({1'b0, 4'(b * 4 + i)});
      for (int i = 0; i < 4; i++) sb.push_back({1'b1, 4'(8 + b * 4 + i)});
    end
    wait_idle(60, "tie");
    chk("tie_writes", nwr, 16);
    chk("tie_span", last_wr - first_wr + 1, 16);
    chk("tie_count", bus.count, 16);
    chk("tie_empty", bus.o_empty, 0);
    chk("tie_busy", bus.busy, 0);
    drain(16);
    chk("drain_count", bus.count, 0);
    chk("drain_empty", bus.o_empty, 1);
    // read while empty is dropped
    bus.rd_req = 1'b1;
    #1 chk("rd_empty_strobe", bus.fifo_rd, 0);
    @(negedge clk);
    chk("rd_empty_count", bus.count, 0);
    bus.rd_req = 1'b0;
    // single requester re-enters its grant every burst
    clr_span();
    send(1, 10, 0);
    wait_idle(60, "single");
    chk("single_writes", nwr, 10);
    chk("single_span", last_wr - first_wr + 1, 10);
    chk("single_count", bus.count, 10);
    drain(10);
    // simultaneous read and write keeps count
    send(0, 5, 0);
    wait_idle(40, "five");
    chk("five_count", bus.count, 5);
    send(0, 1, 5);
    n = 0;
    while (!bus.fifo_wr && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rdwr_timeout", int'(n < 20), 1);
    bus.rd_req = 1'b1;
    #1 chk("rdwr_rd", bus.fifo_rd, 1);
    @(posedge clk);
    #1 bus.rd_req = 1'b0;
    @(negedge clk);
    chk("rdwr_count", bus.count, 5);
    drain(5);
    // fifo_full input stalls the grant
    bus.fifo_full = 1'b1;
    send(0, 1, 3);
    repeat (4) @(negedge clk);
    chk("ffull_wr", bus.fifo_wr, 0);
    chk("ffull_ack0", bus.ack0, 0);
    chk("ffull_busy", bus.busy, 1);
    @(posedge clk);
    #1 bus.fifo_full = 1'b0;
    @(negedge clk);
    chk("ffull_resume", bus.fifo_wr, 1);
    wait_idle(20, "ffull");
    chk("ffull_count", bus.count, 1);
    drain(1);
    // fill to depth, then occupancy blocks writes until a read
    send(0, 64, 0);
    wait_idle(150, "fill");
    chk("fill_count", bus.count, 64);
    chk("fill_empty", bus.o_empty, 0);
    send(0, 1, 10);
    repeat (3) @(negedge clk);
    chk("full_wr", bus.fifo_wr, 0);
    chk("full_ack0", bus.ack0, 0);
    chk("full_count", bus.count, 64);
    chk("full_busy", bus.busy, 1);
    bus.rd_req = 1'b1;
    #1 chk("full_rd", bus.fifo_rd, 1);
    @(posedge clk);
    #1 bus.rd_req = 1'b0;
    @(negedge clk);
    chk("full_after_rd", bus.count, 63);
    chk("full_resume_wr", bus.fifo_wr, 1);
    @(negedge clk);
    chk("full_refill", bus.count, 64);
    wait_idle(20, "full");
    drain(64);
    chk("full_drain", bus.count, 0);
    // core0 drops after 2 words with core1 waiting
    send(0, 2, 1);
    @(negedge clk);
    send(1, 3, 4);
    n = 0;
    while (q0.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("drop_timeout", int'(n < 20), 1);
    chk("drop_grant0", bus.grant_id, 0);
    chk("drop_nowr", bus.fifo_wr, 0);
    @(negedge clk);
    chk("drop_grant1", bus.grant_id, 1);
    chk("drop_ack1", bus.ack1, 1);
    wait_idle(30, "drop");
    chk("drop_count", bus.count, 5);
    drain(5);
    // reset mid-traffic
    for (int i = 0; i < 4; i++) sb.push_back({1'b0, 4'(i)});
    for (int i = 0; i < 4; i++) sb.push_back({1'b1, 4'(8 + i)});
    for (int i = 0; i < 6; i++) begin
      q0.push_back(4'(i));
      q1.push_back(4'(i + 8));
    end
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    bus.rd_req = 1'b1;
    #1;
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_empty", bus.o_empty, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_wr", bus.fifo_wr, 0);
    chk("mid_rst_ack0", bus.ack0, 0);
    chk("mid_rst_ack1", bus.ack1, 0);
    chk("mid_rst_rd", bus.fifo_rd, 0);
    q0.delete();
    q1.delete();
    sb.delete();
    bus.rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_count", bus.count, 0);
    chk("post_rst_busy", bus.busy, 0);
    // tie after reset goes to core0 again
    q0.push_back(4'h7);
    q1.push_back(4'h9);
    sb.push_back({1'b0, 4'h7});
    sb.push_back({1'b1, 4'h9});
    wait_idle(20, "post_rst_tie");
    chk("post_rst_tie_count", bus.count, 2);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
